// File: rtl/snitch_icache_pkg.sv
// Shared types and constants for the instruction-cache miss path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snitch_icache_pkg;

    // Geometry of one cache instance. Field names follow the lookup stage.
    typedef struct packed {
        int unsigned FETCH_AW;
        int unsigned ID_WIDTH_REQ;
        int unsigned SET_COUNT;
        int unsigned SET_ALIGN;
        int unsigned LINE_WIDTH;
        int unsigned LINE_ALIGN;
        int unsigned COUNT_ALIGN;
        int unsigned TAG_WIDTH;
    } config_t;

    // 2 sets of 16 lines of 32 bytes, 32-bit fetch addresses, 4 requesters.
    localparam config_t DEFAULT_CFG = '{
        FETCH_AW     : 32,
        ID_WIDTH_REQ : 4,
        SET_COUNT    : 2,
        SET_ALIGN    : 1,
        LINE_WIDTH   : 256,
        LINE_ALIGN   : 5,
        COUNT_ALIGN  : 4,
        TAG_WIDTH    : 23
    };

    localparam int unsigned DEFAULT_NR_PENDING = 4;
    localparam int unsigned PENDING_ID_WIDTH   = $clog2(DEFAULT_NR_PENDING);

endpackage

// File: rtl/snitch_icache_miss_handler_if.sv
// Bundle of every handshake channel around the miss handler.
// Latency: n/a (wires only).
// Backpressure: each channel carries its own valid/ready pair.
interface snitch_icache_miss_handler_if #(
    parameter snitch_icache_pkg::config_t CFG        = snitch_icache_pkg::DEFAULT_CFG,
    parameter int unsigned                NR_PENDING = snitch_icache_pkg::DEFAULT_NR_PENDING
) ();
    import snitch_icache_pkg::*;

    localparam int unsigned PIW = $clog2(NR_PENDING);

    logic                        flush_valid_i;
    logic                        flush_valid_o;
    logic                        flush_ready_o;

    logic [CFG.FETCH_AW-1:0]     in_addr_i;
    logic [CFG.ID_WIDTH_REQ-1:0] in_id_i;
    logic [CFG.SET_ALIGN-1:0]    in_set_i;
    logic                        in_hit_i;
    logic [CFG.LINE_WIDTH-1:0]   in_data_i;
    logic                        in_error_i;
    logic                        in_valid_i;
    logic                        in_ready_o;

    logic [CFG.LINE_WIDTH-1:0]   rsp_data_o;
    logic                        rsp_error_o;
    logic [CFG.ID_WIDTH_REQ-1:0] rsp_id_o;
    logic                        rsp_valid_o;
    logic                        rsp_ready_i;

    logic [CFG.FETCH_AW-1:0]     refill_addr_o;
    logic [PIW-1:0]              refill_id_o;
    logic                        refill_valid_o;
    logic                        refill_ready_i;

    logic [CFG.LINE_WIDTH-1:0]   refill_data_i;
    logic                        refill_error_i;
    logic [PIW-1:0]              refill_id_i;
    logic                        refill_rsp_valid_i;
    logic                        refill_rsp_ready_o;

    logic [CFG.COUNT_ALIGN-1:0]  write_addr_o;
    logic [CFG.SET_ALIGN-1:0]    write_set_o;
    logic [CFG.LINE_WIDTH-1:0]   write_data_o;
    logic [CFG.TAG_WIDTH-1:0]    write_tag_o;
    logic                        write_error_o;
    logic                        write_valid_o;
    logic                        write_ready_i;

    // Miss handler side.
    modport slave (
        input  flush_valid_i,
        output flush_valid_o, flush_ready_o,
        input  in_addr_i, in_id_i, in_set_i, in_hit_i, in_data_i, in_error_i, in_valid_i,
        output in_ready_o,
        output rsp_data_o, rsp_error_o, rsp_id_o, rsp_valid_o,
        input  rsp_ready_i,
        output refill_addr_o, refill_id_o, refill_valid_o,
        input  refill_ready_i,
        input  refill_data_i, refill_error_i, refill_id_i, refill_rsp_valid_i,
        output refill_rsp_ready_o,
        output write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o, write_valid_o,
        input  write_ready_i
    );

    // Surrounding system side (lookup, fetch, refill, line write).
    modport master (
        output flush_valid_i,
        input  flush_valid_o, flush_ready_o,
        output in_addr_i, in_id_i, in_set_i, in_hit_i, in_data_i, in_error_i, in_valid_i,
        input  in_ready_o,
        input  rsp_data_o, rsp_error_o, rsp_id_o, rsp_valid_o,
        output rsp_ready_i,
        input  refill_addr_o, refill_id_o, refill_valid_o,
        output refill_ready_i,
        output refill_data_i, refill_error_i, refill_id_i, refill_rsp_valid_i,
        input  refill_rsp_ready_o,
        input  write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o, write_valid_o,
        output write_ready_i
    );

endinterface

// File: rtl/snitch_icache_pending_table.sv
// Pending-miss table: line match, lowest-free allocate, id merge, free on refill completion.
// Latency: match/free lookup combinational; updates visible the cycle after the enable.
// Backpressure: none internally; caller gates merge/alloc with its own ready logic.
module snitch_icache_pending_table
    import snitch_icache_pkg::*;
#(
    parameter config_t     CFG        = DEFAULT_CFG,
    parameter int unsigned NR_PENDING = DEFAULT_NR_PENDING
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [CFG.FETCH_AW-1:0]           i_line_addr,
    input  logic [CFG.ID_WIDTH_REQ-1:0]       i_id,
    input  logic                              i_excl_vld,
    input  logic [$clog2(NR_PENDING)-1:0]     i_excl_idx,
    output logic                              o_match_vld,
    output logic                              o_free_vld,
    output logic [$clog2(NR_PENDING)-1:0]     o_free_idx,
    input  logic                              i_merge_en,
    input  logic                              i_alloc_en,
    input  logic                              i_free_en,
    input  logic [$clog2(NR_PENDING)-1:0]     i_free_idx,
    input  logic [$clog2(NR_PENDING)-1:0]     i_rd_idx,
    output logic                              o_rd_vld,
    output logic [CFG.FETCH_AW-1:0]           o_rd_addr,
    output logic [CFG.ID_WIDTH_REQ-1:0]       o_rd_mask,
    output logic [CFG.SET_ALIGN-1:0]          o_rd_set,
    output logic                              o_empty
);
    localparam int unsigned PIW = $clog2(NR_PENDING);
    localparam int unsigned SA  = CFG.SET_ALIGN;

    typedef struct packed {
        logic                        valid;
        logic [CFG.FETCH_AW-1:0]     addr;
        logic [CFG.ID_WIDTH_REQ-1:0] mask;
        logic [SA-1:0]               set;
    } pending_entry_t;

    pending_entry_t          r_entries [NR_PENDING];
    logic [SA-1:0]           r_set_cnt;
    logic [NR_PENDING-1:0]   w_free_mask;
    logic [NR_PENDING-1:0]   w_valid_vec;
    logic                    w_match_vld;
    logic [PIW-1:0]          w_match_idx;
    logic                    w_free_vld;
    logic [PIW-1:0]          w_free_idx;

    // First live entry holding the same line, skipping the one being refilled right now.
    always_comb begin
        w_match_vld = 1'b0;
        w_match_idx = '0;
        for (int i = 0; i < NR_PENDING; i++) begin
            if (!w_match_vld && r_entries[i].valid && (r_entries[i].addr == i_line_addr) &&
                !(i_excl_vld && (i_excl_idx == PIW'(i)))) begin
                w_match_vld = 1'b1;
                w_match_idx = PIW'(i);
            end
        end
    end

    // Lowest free slot; an entry being released this cycle already counts as free.
    always_comb begin
        w_free_vld = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < NR_PENDING; i++) begin
            w_valid_vec[i] = r_entries[i].valid;
            w_free_mask[i] = !r_entries[i].valid || (i_free_en && (i_free_idx == PIW'(i)));
        end
        for (int i = NR_PENDING - 1; i >= 0; i--) begin
            if (w_free_mask[i]) begin
                w_free_vld = 1'b1;
                w_free_idx = PIW'(i);
            end
        end
    end

    assign o_match_vld = w_match_vld;
    assign o_free_vld  = w_free_vld;
    assign o_free_idx  = w_free_idx;
    assign o_empty     = ~|w_valid_vec;
    assign o_rd_vld    = r_entries[i_rd_idx].valid;
    assign o_rd_addr   = r_entries[i_rd_idx].addr;
    assign o_rd_mask   = r_entries[i_rd_idx].mask;
    assign o_rd_set    = r_entries[i_rd_idx].set;

    // Entry updates: release first so a same-index allocation overrides it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_PENDING; i++) begin
                r_entries[i] <= '0;
            end
            r_set_cnt <= '0;
        end else begin
            if (i_free_en) begin
                r_entries[i_free_idx].valid <= 1'b0;
            end
            if (i_merge_en) begin
                r_entries[w_match_idx].mask <= r_entries[w_match_idx].mask | i_id;
            end
            if (i_alloc_en) begin
                r_entries[w_free_idx].valid <= 1'b1;
                r_entries[w_free_idx].addr  <= i_line_addr;
                r_entries[w_free_idx].mask  <= i_id;
                r_entries[w_free_idx].set   <= r_set_cnt;
                r_set_cnt <= (r_set_cnt == SA'(CFG.SET_COUNT - 1)) ? '0 : r_set_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snitch_icache_miss_handler.sv
// Lookup-result sink: hits answered combinationally, misses tracked/merged, refills written back and answered.
// Latency: hit 0 cycles; refill request 1 cycle after allocation; return answered in the cycle it arrives.
// Backpressure: hits stall on rsp_ready or a competing refill response; misses stall on a full table or an unaccepted refill request.
module snitch_icache_miss_handler
    import snitch_icache_pkg::*;
#(
    parameter config_t     CFG        = DEFAULT_CFG,
    parameter int unsigned NR_PENDING = DEFAULT_NR_PENDING
) (
    input logic                         clk_i,
    input logic                         rst_ni,
    snitch_icache_miss_handler_if.slave bus
);
    localparam int unsigned PIW = $clog2(NR_PENDING);
    localparam int unsigned AW  = CFG.FETCH_AW;
    localparam int unsigned LA  = CFG.LINE_ALIGN;

    logic [AW-1:0]               w_line_addr;
    logic                        w_in_hit, w_in_miss;
    logic                        w_match_vld, w_free_vld, w_empty;
    logic [PIW-1:0]              w_free_idx;
    logic                        w_refill_busy, w_can_alloc, w_merge_en, w_alloc_en;
    logic                        w_ret_vld, w_ret_live;
    logic [AW-1:0]               w_ret_addr;
    logic [CFG.ID_WIDTH_REQ-1:0] w_ret_mask;
    logic [CFG.SET_ALIGN-1:0]    w_ret_set;
    logic                        w_ref_rsp_vld, w_wr_vld, w_rsp_fire, w_wr_fire, w_ret_done, w_free_en;
    logic                        w_unused_bits;
    logic                        r_rsp_done, r_wr_done;
    logic                        r_refill_vld;
    logic [AW-1:0]               r_refill_addr;
    logic [PIW-1:0]              r_refill_id;

    assign w_line_addr   = {bus.in_addr_i[AW-1:LA], {LA{1'b0}}};
    assign w_in_hit      = bus.in_valid_i && bus.in_hit_i;
    assign w_in_miss     = bus.in_valid_i && !bus.in_hit_i;
    assign w_refill_busy = r_refill_vld && !bus.refill_ready_i;
    assign w_can_alloc   = w_free_vld && !w_refill_busy;
    assign w_merge_en    = w_in_miss && w_match_vld;
    assign w_alloc_en    = w_in_miss && !w_match_vld && w_can_alloc;

    // Refill return fork: write-back and response complete independently.
    assign w_ret_vld     = bus.refill_rsp_valid_i;
    assign w_ref_rsp_vld = w_ret_vld && w_ret_live && !r_rsp_done;
    assign w_wr_vld      = w_ret_vld && w_ret_live && !r_wr_done;
    assign w_rsp_fire    = w_ref_rsp_vld && bus.rsp_ready_i;
    assign w_wr_fire     = w_wr_vld && bus.write_ready_i;
    assign w_ret_done    = w_ret_vld && (!w_ret_live ||
                           ((r_rsp_done || w_rsp_fire) && (r_wr_done || w_wr_fire)));
    assign w_free_en     = w_ret_done && w_ret_live;

    // The set of the lookup result and the in-line offset of the stored address play no role here.
    assign w_unused_bits = ^{bus.in_set_i, w_ret_addr[LA-1:0]};

    snitch_icache_pending_table #(
        .CFG        (CFG),
        .NR_PENDING (NR_PENDING)
    ) i_pending_table (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_line_addr (w_line_addr),
        .i_id        (bus.in_id_i),
        .i_excl_vld  (w_ret_vld),
        .i_excl_idx  (bus.refill_id_i),
        .o_match_vld (w_match_vld),
        .o_free_vld  (w_free_vld),
        .o_free_idx  (w_free_idx),
        .i_merge_en  (w_merge_en),
        .i_alloc_en  (w_alloc_en),
        .i_free_en   (w_free_en),
        .i_free_idx  (bus.refill_id_i),
        .i_rd_idx    (bus.refill_id_i),
        .o_rd_vld    (w_ret_live),
        .o_rd_addr   (w_ret_addr),
        .o_rd_mask   (w_ret_mask),
        .o_rd_set    (w_ret_set),
        .o_empty     (w_empty)
    );

    // Input acceptance: hits need the response channel, misses need a match or a free slot.
    always_comb begin
        bus.in_ready_o = 1'b0;
        if (bus.in_hit_i) begin
            bus.in_ready_o = bus.rsp_ready_i && !w_ref_rsp_vld;
        end else begin
            bus.in_ready_o = w_match_vld || w_can_alloc;
        end
    end

    // Response mux: a refill return outranks a hit; outputs idle at zero.
    always_comb begin
        bus.rsp_valid_o = 1'b0;
        bus.rsp_data_o  = '0;
        bus.rsp_error_o = 1'b0;
        bus.rsp_id_o    = '0;
        if (w_ref_rsp_vld) begin
            bus.rsp_valid_o = 1'b1;
            bus.rsp_data_o  = bus.refill_data_i;
            bus.rsp_error_o = bus.refill_error_i;
            bus.rsp_id_o    = w_ret_mask;
        end else if (w_in_hit) begin
            bus.rsp_valid_o = 1'b1;
            bus.rsp_data_o  = bus.in_data_i;
            bus.rsp_error_o = bus.in_error_i;
            bus.rsp_id_o    = bus.in_id_i;
        end
    end

    // Line write-back toward the lookup's data/tag arrays; outputs idle at zero.
    always_comb begin
        bus.write_valid_o = 1'b0;
        bus.write_addr_o  = '0;
        bus.write_tag_o   = '0;
        bus.write_set_o   = '0;
        bus.write_data_o  = '0;
        bus.write_error_o = 1'b0;
        if (w_wr_vld) begin
            bus.write_valid_o = 1'b1;
            bus.write_addr_o  = w_ret_addr[LA +: CFG.COUNT_ALIGN];
            bus.write_tag_o   = w_ret_addr[LA + CFG.COUNT_ALIGN +: CFG.TAG_WIDTH];
            bus.write_set_o   = w_ret_set;
            bus.write_data_o  = bus.refill_data_i;
            bus.write_error_o = bus.refill_error_i;
        end
    end

    assign bus.refill_rsp_ready_o = w_ret_done;
    assign bus.refill_valid_o     = r_refill_vld;
    assign bus.refill_addr_o      = r_refill_addr;
    assign bus.refill_id_o        = r_refill_id;
    assign bus.flush_valid_o      = bus.flush_valid_i;
    assign bus.flush_ready_o      = w_empty && !r_refill_vld;

    // Per-path done flags; both clear together once the return is consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_done <= 1'b0;
            r_wr_done  <= 1'b0;
        end else if (w_ret_done) begin
            r_rsp_done <= 1'b0;
            r_wr_done  <= 1'b0;
        end else begin
            if (w_rsp_fire) r_rsp_done <= 1'b1;
            if (w_wr_fire)  r_wr_done  <= 1'b1;
        end
    end

    // Refill request register: loaded on allocation, held until accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_refill_vld  <= 1'b0;
            r_refill_addr <= '0;
            r_refill_id   <= '0;
        end else if (w_alloc_en) begin
            r_refill_vld  <= 1'b1;
            r_refill_addr <= w_line_addr;
            r_refill_id   <= w_free_idx;
        end else if (bus.refill_ready_i) begin
            r_refill_vld  <= 1'b0;
        end
    end

    // A return for an entry that is not pending is swallowed; flag it in simulation.
    a_return_to_live_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.refill_rsp_valid_i |-> w_ret_live);

endmodule

// File: tb/tb_snitch_icache_miss_handler.sv
module tb_snitch_icache_miss_handler;
    import snitch_icache_pkg::*;

    localparam config_t     CFG = DEFAULT_CFG;
    localparam int unsigned NP  = 4;

    localparam logic [255:0] D1 = {8{32'h1111_0040}};
    localparam logic [255:0] D2 = {8{32'h2222_2000}};
    localparam logic [255:0] D3 = {8{32'h3333_3000}};
    localparam logic [255:0] D4 = {8{32'h4444_4000}};
    localparam logic [255:0] D5 = {8{32'h5555_5000}};
    localparam logic [255:0] D6 = {8{32'h6666_1040}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    snitch_icache_miss_handler_if #(.CFG(CFG), .NR_PENDING(NP)) bus ();

    snitch_icache_miss_handler #(.CFG(CFG), .NR_PENDING(NP)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus.flush_valid_i      = 1'b0;
        bus.in_valid_i         = 1'b0;
        bus.in_hit_i           = 1'b0;
        bus.in_addr_i          = '0;
        bus.in_id_i            = '0;
        bus.in_set_i           = '0;
        bus.in_data_i          = '0;
        bus.in_error_i         = 1'b0;
        bus.rsp_ready_i        = 1'b1;
        bus.refill_ready_i     = 1'b1;
        bus.refill_rsp_valid_i = 1'b0;
        bus.refill_data_i      = '0;
        bus.refill_error_i     = 1'b0;
        bus.refill_id_i        = '0;
        bus.write_ready_i      = 1'b1;
    endtask

    task automatic drive_miss(input logic [31:0] addr, input logic [3:0] id);
        bus.in_valid_i = 1'b1;
        bus.in_hit_i   = 1'b0;
        bus.in_addr_i  = addr;
        bus.in_id_i    = id;
    endtask

    task automatic drive_hit(input logic [31:0] addr, input logic [3:0] id, input logic [255:0] d);
        bus.in_valid_i = 1'b1;
        bus.in_hit_i   = 1'b1;
        bus.in_addr_i  = addr;
        bus.in_id_i    = id;
        bus.in_data_i  = d;
    endtask

    task automatic drive_ret(input logic [1:0] id, input logic [255:0] d, input logic err);
        bus.refill_rsp_valid_i = 1'b1;
        bus.refill_id_i        = id;
        bus.refill_data_i      = d;
        bus.refill_error_i     = err;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        settle();
        check("rst_refill_valid", bus.refill_valid_o, 1'b0);
        check("rst_flush_ready", bus.flush_ready_o, 1'b1);
        step();
        rst_n = 1'b1;
    endtask

    // Return sequence for T3: entry index, expected victim set, expected id mask.
    logic [1:0] ret_idx [4] = '{2'd0, 2'd2, 2'd3, 2'd1};
    logic       ret_set [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] ret_msk [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        settle();
        check("rst_refill_valid", bus.refill_valid_o, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        check("rst_write_valid", bus.write_valid_o, 1'b0);
        check("rst_refill_addr", bus.refill_addr_o, 32'h0);
        check("rst_flush_ready", bus.flush_ready_o, 1'b1);
        repeat (2) step();
        rst_n = 1'b1;

        // T1: hit passes straight through
        step(); idle(); drive_hit(32'h1040, 4'b0010, D1); settle();
        check("hit_rsp_valid", bus.rsp_valid_o, 1'b1);
        check("hit_rsp_id", bus.rsp_id_o, 4'b0010);
        check("hit_rsp_data", bus.rsp_data_o, D1);
        check("hit_in_ready", bus.in_ready_o, 1'b1);
        step(); idle(); settle();
        check("hit_no_refill", bus.refill_valid_o, 1'b0);

        // T2: two misses to one line merge into one refill
        step(); idle(); drive_miss(32'h2000, 4'b0001); settle();
        check("m1_in_ready", bus.in_ready_o, 1'b1);
        step(); idle(); drive_miss(32'h2010, 4'b0100); settle();
        check("m2_refill_valid", bus.refill_valid_o, 1'b1);
        check("m2_refill_addr", bus.refill_addr_o, 32'h2000);
        check("m2_refill_id", bus.refill_id_o, 2'd0);
        check("m2_in_ready", bus.in_ready_o, 1'b1);
        step(); idle(); settle();
        check("m2_single_refill", bus.refill_valid_o, 1'b0);
        step(); idle(); drive_ret(2'd0, D2, 1'b0); settle();
        check("m2_rsp_id", bus.rsp_id_o, 4'b0101);
        check("m2_rsp_data", bus.rsp_data_o, D2);
        check("m2_write_addr", bus.write_addr_o, 4'h0);
        check("m2_write_tag", bus.write_tag_o, 23'h10);
        check("m2_write_set", bus.write_set_o, 1'b0);
        check("m2_ret_ready", bus.refill_rsp_ready_o, 1'b1);
        step(); idle(); settle();
        check("m2_flush_ready", bus.flush_ready_o, 1'b1);

        // Reset with a refill request outstanding
        step(); idle(); bus.refill_ready_i = 1'b0; drive_miss(32'h7000, 4'b0001);
        step(); idle(); bus.refill_ready_i = 1'b0; settle();
        check("mid_refill_valid", bus.refill_valid_o, 1'b1);
        check("mid_flush_ready", bus.flush_ready_o, 1'b0);
        do_reset();

        // T3: fill the table, fifth miss stalls until a slot is released
        step(); idle(); drive_miss(32'h3000, 4'b0001); settle();
        check("f0_in_ready", bus.in_ready_o, 1'b1);
        step(); idle(); drive_miss(32'h3020, 4'b0010); settle();
        check("f1_refill_addr", bus.refill_addr_o, 32'h3000);
        step(); idle(); drive_miss(32'h3040, 4'b0100); settle();
        check("f2_refill_id", bus.refill_id_o, 2'd1);
        step(); idle(); drive_miss(32'h3060, 4'b1000); settle();
        check("f3_in_ready", bus.in_ready_o, 1'b1);
        step(); idle(); drive_miss(32'h3080, 4'b0001); settle();
        check("f4_refill_addr", bus.refill_addr_o, 32'h3060);
        check("f4_refill_id", bus.refill_id_o, 2'd3);
        check("f4_stall", bus.in_ready_o, 1'b0);
        step(); settle();
        check("f5_stall", bus.in_ready_o, 1'b0);
        check("f5_flush_ready", bus.flush_ready_o, 1'b0);
        step(); drive_ret(2'd1, D3, 1'b0); settle();
        check("f6_in_ready", bus.in_ready_o, 1'b1);
        check("f6_write_set", bus.write_set_o, 1'b1);
        check("f6_rsp_id", bus.rsp_id_o, 4'b0010);
        check("f6_ret_ready", bus.refill_rsp_ready_o, 1'b1);
        step(); idle(); settle();
        check("f7_refill_addr", bus.refill_addr_o, 32'h3080);
        check("f7_refill_id", bus.refill_id_o, 2'd1);
        for (int i = 0; i < 4; i++) begin
            step(); idle(); drive_ret(ret_idx[i], D3, 1'b0); settle();
            check("f_ret_set", bus.write_set_o, ret_set[i]);
            check("f_ret_mask", bus.rsp_id_o, ret_msk[i]);
            if (ret_idx[i] == 2'd3) begin
                check("f_ret_waddr", bus.write_addr_o, 4'h3);
                check("f_ret_tag", bus.write_tag_o, 23'h18);
            end
        end
        step(); idle(); settle();
        check("f_empty", bus.flush_ready_o, 1'b1);

        // T4: write path stalled three cycles; same-line miss during the return re-allocates
        step(); idle(); drive_miss(32'h4000, 4'b0010);
        step(); idle(); settle();
        check("w_refill_addr", bus.refill_addr_o, 32'h4000);
        step(); idle(); drive_ret(2'd0, D4, 1'b0); bus.write_ready_i = 1'b0; settle();
        check("w0_rsp_valid", bus.rsp_valid_o, 1'b1);
        check("w0_rsp_id", bus.rsp_id_o, 4'b0010);
        check("w0_write_valid", bus.write_valid_o, 1'b1);
        check("w0_ret_ready", bus.refill_rsp_ready_o, 1'b0);
        step(); drive_miss(32'h4000, 4'b0001); settle();
        check("w1_rsp_valid", bus.rsp_valid_o, 1'b0);
        check("w1_ret_ready", bus.refill_rsp_ready_o, 1'b0);
        check("w1_in_ready", bus.in_ready_o, 1'b1);
        step(); bus.in_valid_i = 1'b0; settle();
        check("w2_dup_refill", bus.refill_valid_o, 1'b1);
        check("w2_dup_id", bus.refill_id_o, 2'd1);
        check("w2_ret_ready", bus.refill_rsp_ready_o, 1'b0);
        step(); bus.write_ready_i = 1'b1; settle();
        check("w3_write_valid", bus.write_valid_o, 1'b1);
        check("w3_write_set", bus.write_set_o, 1'b1);
        check("w3_ret_ready", bus.refill_rsp_ready_o, 1'b1);
        step(); idle(); drive_ret(2'd1, D4, 1'b0); settle();
        check("w4_rsp_id", bus.rsp_id_o, 4'b0001);
        check("w4_write_set", bus.write_set_o, 1'b0);
        step(); idle(); settle();
        check("w5_empty", bus.flush_ready_o, 1'b1);

        // T5: refill response beats a concurrent hit; error propagates
        step(); idle(); drive_miss(32'h5000, 4'b0001);
        step(); idle();
        step(); idle(); drive_ret(2'd0, D5, 1'b1); drive_hit(32'h1040, 4'b1000, D6); settle();
        check("e0_rsp_id", bus.rsp_id_o, 4'b0001);
        check("e0_rsp_data", bus.rsp_data_o, D5);
        check("e0_rsp_error", bus.rsp_error_o, 1'b1);
        check("e0_write_error", bus.write_error_o, 1'b1);
        check("e0_hit_stall", bus.in_ready_o, 1'b0);
        step(); bus.refill_rsp_valid_i = 1'b0; bus.refill_error_i = 1'b0; settle();
        check("e1_rsp_id", bus.rsp_id_o, 4'b1000);
        check("e1_rsp_data", bus.rsp_data_o, D6);
        check("e1_rsp_error", bus.rsp_error_o, 1'b0);
        check("e1_in_ready", bus.in_ready_o, 1'b1);

        // T6: flush readiness tracks the outstanding miss
        step(); idle(); bus.flush_valid_i = 1'b1; drive_miss(32'h6000, 4'b0010); settle();
        check("fl0_ready", bus.flush_ready_o, 1'b1);
        check("fl0_pass", bus.flush_valid_o, 1'b1);
        step(); idle(); bus.flush_valid_i = 1'b1; bus.refill_ready_i = 1'b0; settle();
        check("fl1_ready", bus.flush_ready_o, 1'b0);
        step(); bus.refill_ready_i = 1'b1; settle();
        check("fl2_ready", bus.flush_ready_o, 1'b0);
        step(); settle();
        check("fl3_ready", bus.flush_ready_o, 1'b0);
        step(); drive_ret(2'd0, D2, 1'b0); settle();
        check("fl4_ready", bus.flush_ready_o, 1'b0);
        step(); idle(); bus.flush_valid_i = 1'b1; settle();
        check("fl5_ready", bus.flush_ready_o, 1'b1);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/snitch_icache_miss_handler.md
Name: snitch_icache_miss_handler

Overview:
Sits directly downstream of the serial cache lookup stage. It consumes each lookup result and forwards hits as responses to the L0/fetch side. Misses go into a small pending table (MSHR), which issues one refill per line and merges later misses to the same line. When a refill returns, the block writes the line back through the lookup's write port and answers every merged requester.

Parameters:
CFG, '0, snitch_icache_pkg::config_t; provides FETCH_AW, ID_WIDTH_REQ, SET_COUNT, SET_ALIGN, LINE_WIDTH, LINE_ALIGN, COUNT_ALIGN, TAG_WIDTH
NR_PENDING, 4, number of pending-table entries (power of two, ≥2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
flush_valid_i  in  1  flush request, forwarded to lookup
flush_ready_o  out  1  high only when the pending table is empty and no refill request is outstanding
in_addr_i / in_id_i / in_set_i / in_hit_i / in_data_i / in_error_i  in  FETCH_AW / ID_WIDTH_REQ / SET_ALIGN / 1 / LINE_WIDTH / 1  lookup result
in_valid_i  in  1  lookup result valid
in_ready_o  out  1  lookup result accepted
rsp_data_o / rsp_error_o / rsp_id_o  out  LINE_WIDTH / 1 / ID_WIDTH_REQ  response; rsp_id_o is a one-hot OR-mask of requesters
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
refill_addr_o / refill_id_o  out  FETCH_AW / $clog2(NR_PENDING)  line-aligned refill request, tagged with entry index
refill_valid_o  out  1  refill request valid
refill_ready_i  in  1  refill request accepted
refill_data_i / refill_error_i / refill_id_i  in  LINE_WIDTH / 1 / $clog2(NR_PENDING)  refill return
refill_rsp_valid_i  in  1  refill return valid
refill_rsp_ready_o  out  1  refill return accepted
write_addr_o / write_set_o / write_data_o / write_tag_o / write_error_o  out  COUNT_ALIGN / SET_ALIGN / LINE_WIDTH / TAG_WIDTH / 1  line write to lookup
write_valid_o  out  1  line write valid
write_ready_i  in  1  line write accepted

Behaviour:
- Reset: all entries FREE, round-robin set counter = 0, refill_valid_o = 0, all write_* and rsp_* outputs = 0, fork flags cleared.
- Pending entry fields: valid, line address (addr with low LINE_ALIGN bits zeroed), id mask, victim set.
- Hit path: in_hit_i=1 maps to rsp_data = in_data_i, rsp_error = in_error_i, rsp_id = in_id_i.
  - Zero added latency (combinational pass-through).
  - in_ready_o = rsp_ready_i && refill-return path not driving rsp this cycle.
- Miss path: in_hit_i=0.
  - Merge: compare line address against all valid entries, excluding the entry whose refill return is currently being serviced. On a match, OR in_id_i into that entry's mask and accept in the same cycle.
  - Allocate: with no match, take the lowest-index FREE entry. Store victim set = round-robin counter, then increment it, wrapping at SET_COUNT. Assert refill_valid_o next cycle with refill_addr_o = line address and refill_id_o = entry index; hold it until refill_ready_i.
  - Stall (in_ready_o=0) when no entry is FREE, or a previous refill request is not yet accepted.
- Refill return: a two-way fork of the write path and the response path. One done-flag per path; the return is consumed when both are complete.
  - Write path: write_valid_o=1 with write_addr_o = addr[LINE_ALIGN +: COUNT_ALIGN], write_tag_o = addr >> (LINE_ALIGN+COUNT_ALIGN), write_set_o = victim set, write_data_o = refill_data_i, write_error_o = refill_error_i.
  - Response path: rsp_valid_o=1 with rsp_id_o = entry id mask, rsp_data_o = refill_data_i, rsp_error_o = refill_error_i.
  - refill_rsp_ready_o goes high in the cycle the last path completes. In that same cycle the entry returns to FREE and both flags clear.
  - The refill-return path has priority over the hit path on rsp_*.
- Simultaneous events:
  - Merge into an entry in the same cycle its return completes: forbidden by the exclusion rule; a new entry is allocated instead (a duplicate refill is acceptable).
  - Allocation and free of the same index in one cycle: the free is applied first, then the allocation.
- Flush: flush_ready_o = all entries FREE && !refill_valid_o. flush_valid_i is passed through unchanged.
- Reset mid-operation: all state is discarded. Outstanding refill returns after reset are the system's responsibility; a return to a FREE entry is accepted and dropped (assertion in simulation).

Decomposition:
- In snitch_icache_pkg: pending entry struct type, and a localparam for PENDING_ID_WIDTH = $clog2(NR_PENDING).
- Sub-module snitch_icache_pending_table: holds the entries and implements match, allocate, merge and free.
- The top level keeps the hit/refill response arbitration, the write/response fork and the refill-request register.

Test Plan:
- Hit, addr 0x1040, id 4'b0010, rsp_ready=1 -> same cycle rsp_valid=1, rsp_id=4'b0010, data equal; no refill issued.
- Miss 0x2000 id 0001, then miss 0x2010 id 0100 (same 32B line) -> exactly one refill, refill_addr=0x2000, id=0; on return, one rsp with rsp_id=0101.
- Four misses to distinct lines with refill_ready held 1 and no returns -> entries 0..3 allocated, victim sets 0,1,0,1 (SET_COUNT=2); fifth miss stalls with in_ready_o=0 until a return frees an entry.
- Refill return with write_ready_i=0 for 3 cycles and rsp_ready_i=1 -> rsp handshake in cycle 0, write handshake in cycle 3, refill_rsp_ready_o=1 only in cycle 3, entry FREE in cycle 4.
- Refill return and a concurrent hit with rsp_ready_i=1 -> refill response wins, hit stalls one cycle; refill_error_i=1 -> rsp_error_o=1 and write_error_o=1.
- flush_valid_i=1 with one entry pending -> flush_ready_o=0 until that entry's return completes, then 1.
